// File: rtl/rotary_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rotary_pkg
//  Brief    : Shared types and constants for the rotary step controller.
//  Revision : 1.0
// ============================================================================
package rotary_pkg;

    typedef enum logic [2:0] {
        ST_REST = 3'd0,
        ST_CW1  = 3'd1,
        ST_CW2  = 3'd2,
        ST_CW3  = 3'd3,
        ST_CCW1 = 3'd4,
        ST_CCW2 = 3'd5,
        ST_CCW3 = 3'd6
    } quad_state_t;

    // Quadrature codes are {a,b}
    localparam logic [1:0] QC_REST = 2'b11;
    localparam logic [1:0] QC_A    = 2'b01;
    localparam logic [1:0] QC_AB   = 2'b00;
    localparam logic [1:0] QC_B    = 2'b10;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

endpackage
`default_nettype wire

// File: rtl/rotary_step_ctrl_filter.sv
`default_nettype none
// ============================================================================
//  Module   : quad_input_filter
//  Brief    : 2-flop synchronizer for the A/B pins plus an optional counter
//             debouncer, enabled by ROTARY_CTRL_DEBOUNCE_EN.
//  Revision : 1.0
// ============================================================================
module quad_input_filter
    import rotary_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] pins,
    output logic [1:0] ab
);

    logic [1:0] r_sync1;
    logic [1:0] r_sync2;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1 <= QC_REST;
            r_sync2 <= QC_REST;
        end else begin
            r_sync1 <= pins;
            r_sync2 <= r_sync1;
        end
    end

`ifdef ROTARY_CTRL_DEBOUNCE_EN
    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic               r_filt;
        logic [c_CNT_W-1:0] r_cnt;

        // Counts consecutive samples that disagree with the filtered level
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                r_filt <= 1'b1;
                r_cnt  <= '0;
            end else if (r_sync2[i] == r_filt) begin
                r_cnt  <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_filt <= r_sync2[i];
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end

        assign ab[i] = r_filt;
    end
`else
    assign ab = r_sync2;
`endif

endmodule
`default_nettype wire

// File: rtl/rotary_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rotary_step_ctrl
//  Brief    : Quadrature detent decoder with saturating pending-step count and
//             paced step/dir issue. Debounce via ROTARY_CTRL_DEBOUNCE_EN.
//  Revision : 1.0
// ============================================================================
module rotary_step_ctrl
    import rotary_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PACE_CYCLES     = 8,
    parameter int PEND_W          = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              enc_a,
    input  logic              enc_b,
    output logic              step,
    output logic              dir,
    output logic [PEND_W-1:0] pending,
    output logic              ovf
);

    localparam int c_SUM_W  = PEND_W + 2;
    localparam int c_PACE_W = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
    localparam logic [c_PACE_W-1:0]       c_PACE_LOAD = c_PACE_W'(PACE_CYCLES - 1);
    localparam logic signed [c_SUM_W-1:0] c_ONE       = c_SUM_W'(1);
    localparam logic signed [c_SUM_W-1:0] c_MAX       = c_SUM_W'((2 ** (PEND_W - 1)) - 1);
    localparam logic signed [c_SUM_W-1:0] c_MIN       = -c_MAX;

    logic [1:0]                w_ab;
    quad_state_t               r_state;
    quad_state_t               w_state_nxt;
    logic                      w_det_cw;
    logic                      w_det_ccw;
    logic [PEND_W-1:0]         r_pending;
    logic [c_PACE_W-1:0]       r_pace;
    logic                      r_step;
    logic                      r_dir;
    logic                      r_ovf;
    logic                      w_issue;
    logic signed [c_SUM_W-1:0] w_iss;
    logic signed [c_SUM_W-1:0] w_det;
    logic signed [c_SUM_W-1:0] w_base;
    logic signed [c_SUM_W-1:0] w_sum;
    logic                      w_sat;

    quad_input_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_filter (
        .clk  (clk),
        .nrst (nrst),
        .pins ({enc_a, enc_b}),
        .ab   (w_ab)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= ST_REST;
        else       r_state <= w_state_nxt;
    end

    // Codes not listed for a state hold it, except the rest code which always returns to REST
    always_comb begin
        w_state_nxt = r_state;
        w_det_cw    = 1'b0;
        w_det_ccw   = 1'b0;
        case (r_state)
            ST_REST: begin
                if (w_ab == QC_A)         w_state_nxt = ST_CW1;
                else if (w_ab == QC_B)    w_state_nxt = ST_CCW1;
            end
            ST_CW1: begin
                if (w_ab == QC_AB)        w_state_nxt = ST_CW2;
                else if (w_ab == QC_REST) w_state_nxt = ST_REST;
            end
            ST_CW2: begin
                if (w_ab == QC_B)         w_state_nxt = ST_CW3;
                else if (w_ab == QC_A)    w_state_nxt = ST_CW1;
                else if (w_ab == QC_REST) w_state_nxt = ST_REST;
            end
            ST_CW3: begin
                if (w_ab == QC_REST) begin
                    w_state_nxt = ST_REST;
                    w_det_cw    = 1'b1;
                end else if (w_ab == QC_AB) begin
                    w_state_nxt = ST_CW2;
                end
            end
            ST_CCW1: begin
                if (w_ab == QC_AB)        w_state_nxt = ST_CCW2;
                else if (w_ab == QC_REST) w_state_nxt = ST_REST;
            end
            ST_CCW2: begin
                if (w_ab == QC_A)         w_state_nxt = ST_CCW3;
                else if (w_ab == QC_B)    w_state_nxt = ST_CCW1;
                else if (w_ab == QC_REST) w_state_nxt = ST_REST;
            end
            ST_CCW3: begin
                if (w_ab == QC_REST) begin
                    w_state_nxt = ST_REST;
                    w_det_ccw   = 1'b1;
                end else if (w_ab == QC_AB) begin
                    w_state_nxt = ST_CCW2;
                end
            end
            default: w_state_nxt = ST_REST;
        endcase
    end

    // Issue and detent land in the same update; only the detent is ever dropped
    always_comb begin
        w_issue = (r_pace == '0) && (r_pending != '0);
        w_iss   = '0;
        if (w_issue) w_iss = r_pending[PEND_W-1] ? -c_ONE : c_ONE;
        w_det   = '0;
        if (w_det_cw)       w_det = c_ONE;
        else if (w_det_ccw) w_det = -c_ONE;
        w_base  = $signed({{2{r_pending[PEND_W-1]}}, r_pending}) - w_iss;
        w_sum   = w_base + w_det;
        w_sat   = (w_sum > c_MAX) || (w_sum < c_MIN);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pending <= '0;
            r_pace    <= '0;
            r_step    <= 1'b0;
            r_dir     <= DIR_CCW;
            r_ovf     <= 1'b0;
        end else begin
            r_pending <= w_sat ? w_base[PEND_W-1:0] : w_sum[PEND_W-1:0];
            r_step    <= w_issue;
            if (w_sat) r_ovf <= 1'b1;
            if (w_issue) begin
                r_dir  <= r_pending[PEND_W-1] ? DIR_CCW : DIR_CW;
                r_pace <= c_PACE_LOAD;
            end else if (r_pace != '0) begin
                r_pace <= r_pace - 1'b1;
            end
        end
    end

    assign step    = r_step;
    assign dir     = r_dir;
    assign pending = r_pending;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire
